// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI mode-0 responder.
package spi_pkg;

    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BIT_CTR_W       = 3;

    localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'hff;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for an asynchronous pin plus single-cycle rise/fall events.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SPI_SYNC_STAGES-1:0] sync_q;
    logic                       edge_q;
    logic                       level;

    // Chain resets low so a pin already low at reset release never yields a fall event.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
            edge_q <= sync_q[SPI_SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SPI_SYNC_STAGES-1];
    assign rise_c = level & ~edge_q;
    assign fall_c = ~level & edge_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder: oversampled pins, rx byte strobe, one-entry tx holding buffer.
module spi_target
    import spi_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_ss,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_en,
    output logic              selected,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              underrun,
    input  logic              underrun_clr
);

    spi_state_e state, state_next;

    logic ss_rise_c, ss_fall_c, sck_rise_c, sck_fall_c;
    logic [SPI_SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    logic [BYTE_W-1:0]    tx_shift;
    logic [BYTE_W-1:0]    tx_buf;
    logic [BYTE_W-2:0]    rx_shift;
    logic [BYTE_W-1:0]    rx_next;
    logic [BIT_CTR_W-1:0] bit_ctr;

    logic start_c, load_c, shift_c, drop_c, rx_step_c, accept_c;

    spi_sync_edge u_ss_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (spi_ss),
        .rise_c (ss_rise_c),
        .fall_c (ss_fall_c)
    );

    spi_sync_edge u_sck_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (spi_sck),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    // mosi taken from the same stage depth as the sck edge detector for alignment
    always_ff @(posedge clk) begin
        if (reset) mosi_q <= '0;
        else       mosi_q <= {mosi_q[SPI_SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_q[SPI_SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_HIGH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_HIGH: if (ss_rise_c) state_next = IDLE;
            IDLE:      if (ss_fall_c) state_next = ACTIVE;
            ACTIVE:    if (ss_rise_c) state_next = IDLE;
            default:   state_next = WAIT_HIGH;
        endcase
    end

    // Deselect wins over any sck event seen in the same cycle.
    always_comb begin
        start_c   = 1'b0;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        drop_c    = 1'b0;
        rx_step_c = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall_c) begin
                    start_c = 1'b1;
                    load_c  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise_c) begin
                    drop_c = 1'b1;
                end else begin
                    rx_step_c = sck_rise_c;
                    if (sck_fall_c) begin
                        if (bit_ctr == '0) load_c  = 1'b1;
                        else               shift_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign accept_c = tx_valid & tx_ready;
    assign rx_next  = {rx_shift, mosi_s};
    assign spi_miso = tx_shift[BYTE_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_ready    <= 1'b1;
            underrun    <= 1'b0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_ctr     <= '0;
            selected    <= 1'b0;
            spi_miso_en <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            selected    <= (state_next == ACTIVE);
            spi_miso_en <= (state_next == ACTIVE);

            // A load sees the buffer as it was before any same-cycle accept.
            if (accept_c)    tx_buf <= tx_data;
            if (accept_c)    tx_ready <= 1'b0;
            else if (load_c) tx_ready <= 1'b1;

            if (load_c && tx_ready) underrun <= 1'b1;
            else if (underrun_clr)  underrun <= 1'b0;

            if (load_c)       tx_shift <= tx_ready ? IDLE_BYTE : tx_buf;
            else if (shift_c) tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            else if (drop_c)  tx_shift <= '0;

            if (start_c)        bit_ctr <= '0;
            else if (rx_step_c) bit_ctr <= bit_ctr + BIT_CTR_W'(1);

            if (rx_step_c) begin
                rx_shift <= rx_next[BYTE_W-2:0];
                if (bit_ctr == BIT_CTR_W'(BYTE_W - 1)) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: table vectors, hand sequences and random transactions.
module tb_spi_target;

    localparam int HALF = 4;

    logic       clk;
    logic       reset;
    logic       spi_ss, spi_sck, spi_mosi;
    logic       spi_miso, spi_miso_en, selected;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       underrun, underrun_clr;

    int n_tests;
    int n_fail;
    logic [7:0] rx_q[$];

    // mode per slot: 0 = not offered, 1 = offered mid-byte, 2 = offered on the load cycle
    typedef struct {
        int              n;
        logic [3:0][7:0] mosi;
        logic [3:0][7:0] txb;
        logic [3:0][1:0] mode;
        logic [3:0][7:0] exp_miso;
        logic            exp_ur_mid;
        logic            exp_ur_end;
    } vec_t;

    vec_t vecs[6];
    vec_t v;

    spi_target dut (
        .clk          (clk),
        .reset        (reset),
        .spi_ss       (spi_ss),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_en  (spi_miso_en),
        .selected     (selected),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":miso"},     32'(spi_miso),    32'(0));
        chk({tag, ":miso_en"},  32'(spi_miso_en), 32'(0));
        chk({tag, ":selected"}, 32'(selected),    32'(0));
        chk({tag, ":rx_data"},  32'(rx_data),     32'(0));
        chk({tag, ":rx_valid"}, 32'(rx_valid),    32'(0));
        chk({tag, ":tx_ready"}, 32'(tx_ready),    32'(1));
        chk({tag, ":underrun"}, 32'(underrun),    32'(0));
    endtask

    task automatic offer(input logic [7:0] b, input string tag);
        tx_data  = b;
        tx_valid = 1'b1;
        chk({tag, ":tx_ready_at_offer"}, 32'(tx_ready), 32'(1));
        clk_wait(1);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input vec_t t, input string tag);
        logic [7:0] got;
        underrun_clr = 1'b1;
        clk_wait(1);
        underrun_clr = 1'b0;
        clk_wait(1);
        chk({tag, ":ur_clr"}, 32'(underrun), 32'(0));
        rx_q.delete();
        if (t.mode[0] == 2'd1) offer(t.txb[0], tag);
        spi_ss = 1'b0;
        clk_wait(2);
        for (int b = 0; b < t.n; b++) begin
            got = '0;
            for (int k = 0; k < 8; k++) begin
                spi_mosi = t.mosi[b][7-k];
                if (k == 0 && b > 0 && t.mode[b] == 2'd2) begin
                    clk_wait(2);
                    offer(t.txb[b], tag);
                    clk_wait(HALF - 3);
                end else if (k == 3 && t.mode[b+1] == 2'd1) begin
                    offer(t.txb[b+1], tag);
                    clk_wait(HALF - 1);
                end else begin
                    clk_wait(HALF);
                end
                if (b == 0 && k == 0) begin
                    chk({tag, ":selected"}, 32'(selected),    32'(1));
                    chk({tag, ":miso_en"},  32'(spi_miso_en), 32'(1));
                end
                got[7-k] = spi_miso;
                spi_sck = 1'b1;
                clk_wait(HALF);
                if (b == t.n - 1 && k == 7)
                    chk({tag, ":ur_mid"}, 32'(underrun), 32'(t.exp_ur_mid));
                spi_sck = 1'b0;
            end
            chk({tag, ":miso_byte"}, 32'(got), 32'(t.exp_miso[b]));
        end
        clk_wait(HALF);
        spi_ss = 1'b1;
        clk_wait(4);
        chk({tag, ":miso_en_off"}, 32'(spi_miso_en), 32'(0));
        chk({tag, ":sel_off"},     32'(selected),    32'(0));
        chk({tag, ":ur_end"},      32'(underrun),    32'(t.exp_ur_end));
        chk({tag, ":tx_ready_end"}, 32'(tx_ready),   32'(1));
        chk({tag, ":rx_count"},    32'(rx_q.size()), 32'(t.n));
        for (int i = 0; i < t.n && i < rx_q.size(); i++)
            chk({tag, ":rx_byte"}, 32'(rx_q[i]), 32'(t.mosi[i]));
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        spi_ss       = 1'b1;
        spi_sck      = 1'b0;
        spi_mosi     = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        underrun_clr = 1'b0;

        vecs[0] = '{n: 1, mosi: 32'h0000003C, txb: 32'h000000A5, mode: 8'h01,
                    exp_miso: 32'h000000A5, exp_ur_mid: 1'b0, exp_ur_end: 1'b1};
        vecs[1] = '{n: 2, mosi: 32'h0000FE01, txb: 32'h00005AA5, mode: 8'h05,
                    exp_miso: 32'h00005AA5, exp_ur_mid: 1'b0, exp_ur_end: 1'b1};
        vecs[2] = '{n: 1, mosi: 32'h00000081, txb: 32'h00000000, mode: 8'h00,
                    exp_miso: 32'h000000FF, exp_ur_mid: 1'b1, exp_ur_end: 1'b1};
        vecs[3] = '{n: 3, mosi: 32'h00F00F80, txb: 32'hDEADBEEF, mode: 8'h55,
                    exp_miso: 32'h00ADBEEF, exp_ur_mid: 1'b0, exp_ur_end: 1'b0};
        vecs[4] = '{n: 3, mosi: 32'h0055FF00, txb: 32'h00563412, mode: 8'h51,
                    exp_miso: 32'h0056FF12, exp_ur_mid: 1'b1, exp_ur_end: 1'b1};
        vecs[5] = '{n: 3, mosi: 32'h00332211, txb: 32'h000077C3, mode: 8'h09,
                    exp_miso: 32'h0077FFC3, exp_ur_mid: 1'b1, exp_ur_end: 1'b1};

        clk_wait(3);
        chk_reset_vals("por");
        reset = 1'b0;
        clk_wait(6);

        for (int i = 0; i < 6; i++) xfer(vecs[i], $sformatf("vec%0d", i));

        // set on a load point beats a simultaneous clear
        chk("ur_pre", 32'(underrun), 32'(1));
        rx_q.delete();
        spi_ss = 1'b0;
        clk_wait(2);
        underrun_clr = 1'b1;
        clk_wait(1);
        underrun_clr = 1'b0;
        chk("ur_set_beats_clr", 32'(underrun), 32'(1));
        chk("ur_sel", 32'(selected), 32'(1));

        // abort after 5 sck edges
        spi_mosi = 1'b1;
        clk_wait(HALF);
        for (int e = 0; e < 5; e++) begin
            spi_sck = ~spi_sck;
            clk_wait(HALF);
        end
        spi_ss = 1'b1;
        clk_wait(4);
        chk("abort:miso_en", 32'(spi_miso_en), 32'(0));
        chk("abort:sel",     32'(selected),    32'(0));
        spi_sck = 1'b0;
        clk_wait(HALF);
        chk("abort:no_rx", 32'(rx_q.size()), 32'(0));

        v = '{n: 2, mosi: 32'h00004B96, txb: 32'h0000B469, mode: 8'h05,
              exp_miso: 32'h0000B469, exp_ur_mid: 1'b0, exp_ur_end: 1'b1};
        xfer(v, "post_abort");

        // reset mid-byte with ss held low
        offer(8'h3C, "rst");
        rx_q.delete();
        spi_ss = 1'b0;
        clk_wait(2 + HALF);
        spi_sck = 1'b1;
        clk_wait(HALF);
        spi_sck = 1'b0;
        clk_wait(HALF);
        spi_sck = 1'b1;
        clk_wait(2);
        reset = 1'b1;
        clk_wait(1);
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        spi_sck = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clk_wait(HALF);
            spi_sck = 1'b1;
            clk_wait(HALF);
            spi_sck = 1'b0;
        end
        clk_wait(HALF);
        chk("rst_hold:sel",      32'(selected),    32'(0));
        chk("rst_hold:miso_en",  32'(spi_miso_en), 32'(0));
        chk("rst_hold:no_rx",    32'(rx_q.size()), 32'(0));
        chk("rst_hold:tx_ready", 32'(tx_ready),    32'(1));
        spi_ss = 1'b1;
        clk_wait(6);
        v = '{n: 1, mosi: 32'h000000C7, txb: 32'h0000E100, mode: 8'h05,
              exp_miso: 32'h00000000, exp_ur_mid: 1'b0, exp_ur_end: 1'b0};
        v.exp_miso[0] = v.txb[0];
        xfer(v, "post_rst");

        // random transactions against a slot-level model
        for (int r = 0; r < 16; r++) begin
            v.n = int'($urandom_range(1, 3));
            v.exp_ur_mid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                v.mosi[i] = 8'($urandom);
                v.txb[i]  = 8'($urandom);
                v.mode[i] = 2'($urandom_range(0, 1));
                v.exp_miso[i] = (v.mode[i] == 2'd1) ? v.txb[i] : 8'hFF;
                if (i < v.n && v.mode[i] != 2'd1) v.exp_ur_mid = 1'b1;
            end
            v.exp_ur_end = v.exp_ur_mid | (v.mode[v.n] != 2'd1);
            xfer(v, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
